// File: rtl/pio_cmd_bridge_pkg.sv
// Shared types and derived-width helpers for the HPS PIO command bridge.
package pio_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP,
        PUSH
    } state_e;

    // Status bit positions, counted down from the MSB of hps_rsp.
    localparam int RSP_NE_BIT   = 0;
    localparam int RSP_ERR_BIT  = 1;
    localparam int RSP_BUSY_BIT = 2;

    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int pay_w(input int cmd_w, input int num_ch);
        return cmd_w - 1 - ch_w(num_ch);
    endfunction

    function automatic int data_w(input int rsp_w);
        return rsp_w - 3;
    endfunction

endpackage

// File: rtl/pio_cmd_bridge_rsp_fifo.sv
// Synchronous response FIFO; pointers carry one extra wrap bit to tell full from empty.
module rsp_fifo #(
    parameter int WIDTH = 29,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop  = pop && !empty;
        // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
        do_push = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        dout     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/pio_cmd_bridge.sv
// Toggle-framed HPS command dispatcher to NUM_CH accelerator channels with a
// response FIFO drained by an HPS ack toggle.
module pio_cmd_bridge
    import pio_bridge_pkg::*;
#(
    parameter int CMD_W     = 20,
    parameter int RSP_W     = 32,
    parameter int NUM_CH    = 4,
    parameter int RSP_DEPTH = 4,
    parameter int TIMEOUT   = 1024,
    localparam int CH_W     = ch_w(NUM_CH),
    localparam int PAY_W    = pay_w(CMD_W, NUM_CH),
    localparam int DATA_W   = data_w(RSP_W)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CMD_W-1:0]         hps_cmd,
    input  logic                     hps_ack,
    output logic [RSP_W-1:0]         hps_rsp,
    output logic [NUM_CH-1:0]        ch_req_valid,
    output logic [PAY_W-1:0]         ch_req_data,
    input  logic [NUM_CH-1:0]        ch_req_ready,
    input  logic [NUM_CH-1:0]        ch_rsp_valid,
    input  logic [NUM_CH*DATA_W-1:0] ch_rsp_data
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic              ack_q, ack_d;
    logic              prev_req_q, prev_req_d;
    logic              prev_ack_q, prev_ack_d;

    state_e            state_q;
    logic [CH_W-1:0]   ch_q;
    logic [PAY_W-1:0]  pay_q;
    logic [NUM_CH-1:0] req_valid_q;
    logic [DATA_W-1:0] rsp_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              req_edge, ack_edge, busy, cmd_ch_ok, timed_out, push_ok;
    logic [CH_W-1:0]   cmd_ch;
    logic [PAY_W-1:0]  cmd_pay;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_full, fifo_empty;

    // Toggle history loads the live input during reset so a held level is not an edge.
    always_comb begin
        cmd_d      = hps_cmd;
        ack_d      = hps_ack;
        prev_req_d = reset ? hps_cmd[CMD_W-1] : cmd_q[CMD_W-1];
        prev_ack_d = reset ? hps_ack : ack_q;
        req_edge   = (cmd_q[CMD_W-1] != prev_req_q);
        ack_edge   = (ack_q != prev_ack_q);
        cmd_ch     = cmd_q[CMD_W-2 -: CH_W];
        cmd_pay    = cmd_q[PAY_W-1:0];
        cmd_ch_ok  = (int'(cmd_ch) < NUM_CH);
        busy       = (state_q != IDLE);
        timed_out  = (cnt_q >= CNT_W'(TIMEOUT - 1));
        push_ok    = !fifo_full || ack_edge;
    end

    always_ff @(posedge clk) begin
        cmd_q      <= cmd_d;
        ack_q      <= ack_d;
        prev_req_q <= prev_req_d;
        prev_ack_q <= prev_ack_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            pay_q       <= '0;
            req_valid_q <= '0;
            rsp_q       <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_edge) begin
                        if (cmd_ch_ok) begin
                            ch_q        <= cmd_ch;
                            pay_q       <= cmd_pay;
                            err_q       <= 1'b0;
                            cnt_q       <= '0;
                            req_valid_q <= NUM_CH'(1) << cmd_ch;
                            state_q     <= ISSUE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (ch_req_ready[ch_q]) begin
                        req_valid_q <= '0;
                        cnt_q       <= cnt_q + CNT_W'(1);
                        state_q     <= WAIT_RSP;
                    end else if (timed_out) begin
                        req_valid_q <= '0;
                        err_q       <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WAIT_RSP: begin
                    if (ch_rsp_valid[ch_q]) begin
                        rsp_q   <= ch_rsp_data[int'(ch_q)*DATA_W +: DATA_W];
                        state_q <= PUSH;
                    end else if (timed_out) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                PUSH: begin
                    if (push_ok) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (req_edge && state_q != IDLE) begin
                err_q <= 1'b1;
            end
        end
    end

    rsp_fifo #(
        .WIDTH(DATA_W),
        .DEPTH(RSP_DEPTH)
    ) u_rsp_fifo (
        .clk  (clk),
        .reset(reset),
        .push (state_q == PUSH),
        .pop  (ack_edge),
        .din  (rsp_q),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        hps_rsp                           = '0;
        hps_rsp[RSP_W-1-RSP_NE_BIT]       = !fifo_empty;
        hps_rsp[RSP_W-1-RSP_ERR_BIT]      = err_q;
        hps_rsp[RSP_W-1-RSP_BUSY_BIT]     = busy;
        hps_rsp[DATA_W-1:0]               = fifo_dout;
        ch_req_valid                      = req_valid_q;
        ch_req_data                       = pay_q;
    end

endmodule

// File: tb/tb_pio_cmd_bridge.sv
// Directed/randomized bench for pio_cmd_bridge against a queue-based reference model.
module tb_pio_cmd_bridge;

    localparam int CMD_W     = 20;
    localparam int RSP_W     = 32;
    localparam int NUM_CH    = 4;
    localparam int RSP_DEPTH = 4;
    localparam int TIMEOUT   = 16;
    localparam int DATA_W    = 29;
    localparam int PAY_W     = 17;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [CMD_W-1:0]         hps_cmd;
    logic                     hps_ack;
    logic [RSP_W-1:0]         hps_rsp;
    logic [NUM_CH-1:0]        ch_req_valid;
    logic [PAY_W-1:0]         ch_req_data;
    logic [NUM_CH-1:0]        ch_req_ready;
    logic [NUM_CH-1:0]        ch_rsp_valid;
    logic [NUM_CH*DATA_W-1:0] ch_rsp_data;

    always #5 clk = ~clk;

    pio_cmd_bridge #(
        .CMD_W    (CMD_W),
        .RSP_W    (RSP_W),
        .NUM_CH   (NUM_CH),
        .RSP_DEPTH(RSP_DEPTH),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hps_cmd     (hps_cmd),
        .hps_ack     (hps_ack),
        .hps_rsp     (hps_rsp),
        .ch_req_valid(ch_req_valid),
        .ch_req_data (ch_req_data),
        .ch_req_ready(ch_req_ready),
        .ch_rsp_valid(ch_rsp_valid),
        .ch_rsp_data (ch_rsp_data)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: FIFO contents and the sticky error flag.
    logic [DATA_W-1:0] q[$];
    bit                m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rsp(input bit busy);
        logic [31:0] r;
        r     = '0;
        r[31] = (q.size() != 0);
        r[30] = m_err;
        r[29] = busy;
        if (q.size() != 0) r[28:0] = q[0];
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int ch, input logic [PAY_W-1:0] pay);
        hps_cmd = {~hps_cmd[CMD_W-1], 2'(ch), pay};
        tick;
        check("valid_latency", 32'(ch_req_valid), 32'd0);
        tick;
        m_err = 1'b0;
        check("req_valid", 32'(ch_req_valid), 32'(1 << ch));
        check("req_data", 32'(ch_req_data), 32'(pay));
        check("rsp_issue", hps_rsp, exp_rsp(1'b1));
    endtask

    task automatic handshake(input int ch, input int dly);
        ch_req_ready = ~4'(1 << ch);
        for (int i = 0; i < dly; i++) begin
            tick;
            check("valid_hold", 32'(ch_req_valid), 32'(1 << ch));
        end
        ch_req_ready = 4'(1 << ch);
        tick;
        ch_req_ready = '0;
        check("valid_drop", 32'(ch_req_valid), 32'd0);
    endtask

    task automatic respond(input int ch, input logic [DATA_W-1:0] d, input int dly);
        int oc;
        oc = (ch + 1) % NUM_CH;
        for (int i = 0; i < dly; i++) begin
            if (i == 0) begin
                ch_rsp_valid = 4'(1 << oc);
                ch_rsp_data[oc*DATA_W +: DATA_W] = ~d;
            end
            tick;
            ch_rsp_valid = '0;
            ch_rsp_data  = '0;
        end
        ch_rsp_valid = 4'(1 << ch);
        ch_rsp_data[ch*DATA_W +: DATA_W] = d;
        tick;
        ch_rsp_valid = '0;
        ch_rsp_data  = '0;
        check("in_push", hps_rsp, exp_rsp(1'b1));
    endtask

    task automatic push_done(input logic [DATA_W-1:0] d);
        tick;
        q.push_back(d);
        check("pushed", hps_rsp, exp_rsp(1'b0));
    endtask

    task automatic ack_pop;
        hps_ack = ~hps_ack;
        tick;
        check("ack_latency", hps_rsp, exp_rsp(1'b0));
        tick;
        if (q.size() != 0) void'(q.pop_front());
        check("popped", hps_rsp, exp_rsp(1'b0));
    endtask

    task automatic txn(input int ch);
        logic [PAY_W-1:0]  pay;
        logic [DATA_W-1:0] d;
        pay = PAY_W'($urandom());
        d   = DATA_W'($urandom());
        issue(ch, pay);
        handshake(ch, int'($urandom_range(0, 3)));
        respond(ch, d, int'($urandom_range(0, 4)));
        push_done(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] d5;
        int n;
        int ch;

        // Reset with both toggles held high
        reset        = 1'b1;
        hps_cmd      = 20'h80000;
        hps_ack      = 1'b1;
        ch_req_ready = '0;
        ch_rsp_valid = '0;
        ch_rsp_data  = '0;
        m_err        = 1'b0;
        repeat (3) tick;
        reset = 1'b0;
        check("reset_rsp", hps_rsp, 32'h0);
        check("reset_valid", 32'(ch_req_valid), 32'd0);
        repeat (3) begin
            tick;
            check("post_reset_valid", 32'(ch_req_valid), 32'd0);
            check("post_reset_rsp", hps_rsp, 32'h0);
        end

        // Basic transaction on channel 1
        issue(1, 17'h00ABC);
        handshake(1, 3);
        respond(1, 29'h1234567, 2);
        push_done(29'h1234567);
        check("basic_rsp", hps_rsp, 32'h81234567);
        ack_pop;
        check("basic_drained", hps_rsp, 32'h0);

        // Ack while empty is ignored
        hps_ack = ~hps_ack;
        tick;
        tick;
        check("empty_ack", hps_rsp, 32'h0);

        // Fill the FIFO, then stall the fifth push until an ack frees a slot
        repeat (RSP_DEPTH) txn(int'($urandom_range(0, NUM_CH - 1)));
        ch = int'($urandom_range(0, NUM_CH - 1));
        d5 = DATA_W'($urandom());
        issue(ch, PAY_W'($urandom()));
        handshake(ch, 0);
        respond(ch, d5, 1);
        repeat (3) begin
            tick;
            check("stall_busy", hps_rsp, exp_rsp(1'b1));
        end
        hps_ack = ~hps_ack;
        tick;
        check("stall_ack_latency", hps_rsp, exp_rsp(1'b1));
        tick;
        void'(q.pop_front());
        q.push_back(d5);
        check("stall_release", hps_rsp, exp_rsp(1'b0));
        repeat (RSP_DEPTH) ack_pop;
        check("full_drained", hps_rsp, 32'h0);

        // Timeout: channel 2 accepts but never responds
        issue(2, PAY_W'($urandom()));
        ch_req_ready = 4'b0100;
        n = 0;
        while (n < 100) begin
            tick;
            n++;
            ch_req_ready = '0;
            if (!hps_rsp[29]) break;
        end
        check("timeout_cycles", 32'(n), 32'(TIMEOUT));
        m_err = 1'b1;
        check("timeout_err", hps_rsp, exp_rsp(1'b0));
        ch_rsp_valid = 4'b0100;
        ch_rsp_data[2*DATA_W +: DATA_W] = DATA_W'($urandom());
        tick;
        ch_rsp_valid = '0;
        ch_rsp_data  = '0;
        tick;
        tick;
        check("late_rsp_ignored", hps_rsp, exp_rsp(1'b0));
        txn(0);
        check("err_cleared", 32'(hps_rsp[30]), 32'd0);
        ack_pop;

        // Request while busy is dropped and flags err; original completes
        d5 = DATA_W'($urandom());
        issue(3, PAY_W'($urandom()));
        handshake(3, 1);
        hps_cmd = {~hps_cmd[CMD_W-1], 2'd0, PAY_W'($urandom())};
        tick;
        tick;
        m_err = 1'b1;
        check("busy_req_err", hps_rsp, exp_rsp(1'b1));
        respond(3, d5, 1);
        push_done(d5);
        repeat (4) begin
            tick;
            check("dropped_not_issued", 32'(ch_req_valid), 32'd0);
        end
        ack_pop;

        // Reset during WAIT_RSP with two entries queued
        txn(int'($urandom_range(0, NUM_CH - 1)));
        txn(int'($urandom_range(0, NUM_CH - 1)));
        issue(1, PAY_W'($urandom()));
        handshake(1, 0);
        reset = 1'b1;
        tick;
        check("midreset_rsp", hps_rsp, 32'h0);
        check("midreset_valid", 32'(ch_req_valid), 32'd0);
        reset = 1'b0;
        q.delete();
        m_err = 1'b0;
        repeat (3) begin
            tick;
            check("after_midreset_rsp", hps_rsp, 32'h0);
            check("after_midreset_valid", 32'(ch_req_valid), 32'd0);
        end

        // Randomized traffic with interleaved drains
        repeat (8) begin
            if (q.size() == RSP_DEPTH) ack_pop;
            txn(int'($urandom_range(0, NUM_CH - 1)));
            if ($urandom_range(0, 1) == 1) ack_pop;
        end
        repeat (RSP_DEPTH) begin
            if (q.size() != 0) ack_pop;
        end
        check("final_empty", hps_rsp, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
